// File: rtl/seq_pkg.sv
// Shared types and helpers for the step sequencer: note width, rest code,
// sequencer state encoding and the note-request priority encoder.
package seq_pkg;

   localparam int unsigned NOTE_W = 3;
   localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;

   typedef enum logic [0:0] {
      IDLE,
      PLAY
   } state_t;

   // Lowest-index request wins; scanning downwards lets the last hit be the lowest bit.
   function automatic logic [NOTE_W-1:0] note_encode(input logic [5:0] req);
      logic [NOTE_W-1:0] enc;
      enc = NOTE_REST;
      for (int i = 5; i >= 0; i--) begin
         if (req[i]) enc = NOTE_W'(i + 1);
      end
      return enc;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by reset.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer: plays and live-records an N-step note pattern and
// drives the shared oscillator's pitch select and gate.
module step_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned STEPS    = 8,
   parameter int unsigned STEP_DIV = 524288,
   parameter int unsigned GATE_DIV = 262144
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     rec,
   input  logic [5:0]               note_req,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic [NOTE_W-1:0]        note,
   output logic                     gate,
   output logic                     step_tick
);

   localparam int unsigned SW = $clog2(STEPS);
   localparam int unsigned CW = $clog2(STEP_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
   // One extra bit so GATE_DIV == STEP_DIV (gate always on) is representable.
   localparam logic [CW:0]   GATE_LIM = (CW + 1)'(GATE_DIV);

   logic                           run_s;
   logic                           rec_s;
   logic [5:0]                     req_s;
   logic [NOTE_W-1:0]              enc;
   logic                           last;
   logic                           monitor;

   state_t                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [SW-1:0]                  step_q, step_d;
   logic                           seen_q, seen_d;
   logic [STEPS-1:0][NOTE_W-1:0]   pattern_q, pattern_d;
   logic [NOTE_W-1:0]              note_d;
   logic                           gate_d;
   logic                           tick_d;

   sync2 #(
      .WIDTH(8)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  ({run, rec, note_req}),
      .q  ({run_s, rec_s, req_s})
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      step_d    = step_q;
      seen_d    = seen_q;
      pattern_d = pattern_q;
      enc       = note_encode(req_s);
      last      = (cnt_q == CNT_LAST);

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run_s) begin
               state_d = PLAY;
               step_d  = '0;
               seen_d  = 1'b0;
            end
         end
         PLAY: begin
            if (rec_s) begin
               if (enc != NOTE_REST) begin
                  pattern_d[step_q] = enc;
                  seen_d            = 1'b1;
               end else if (last && !seen_q) begin
                  pattern_d[step_q] = NOTE_REST;
               end
            end
            if (last) begin
               cnt_d  = '0;
               step_d = step_q + SW'(1);
               seen_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (!run_s) begin
               state_d = IDLE;
               cnt_d   = '0;
               step_d  = step_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are computed from next state so they line up with step_idx.
      monitor = (state_q == PLAY) && (state_d == PLAY) && rec_s && (enc != NOTE_REST);
      note_d  = monitor ? enc : pattern_d[step_d];
      gate_d  = monitor ||
                ((state_d == PLAY) && (note_d != NOTE_REST) && ({1'b0, cnt_d} < GATE_LIM));
      tick_d  = (state_d == PLAY) && (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         step_q    <= '0;
         seen_q    <= 1'b0;
         pattern_q <= '0;
         note      <= NOTE_REST;
         gate      <= 1'b0;
         step_tick <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         seen_q    <= seen_d;
         pattern_q <= pattern_d;
         note      <= note_d;
         gate      <= gate_d;
         step_tick <= tick_d;
      end
   end

   assign step_idx = step_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomised self-checking bench for step_sequencer against a behavioural model.
module tb_step_sequencer;

   localparam int STEPS    = 4;
   localparam int STEP_DIV = 16;
   localparam int GATE_DIV = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       rec = 1'b0;
   logic [5:0] note_req = 6'd0;
   logic [1:0] step_idx;
   logic [2:0] note;
   logic       gate;
   logic       step_tick;
   logic [6:0] obs;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit         m_play;
   int         m_pos;
   int         m_step;
   int         m_pat [STEPS];
   bit         m_seen;
   bit         m_mon;
   int         m_note;
   bit         m_gate;
   bit         m_tick;
   logic [7:0] m_pipe [2];
   logic [6:0] m_exp;

   always #5 clk = ~clk;

   step_sequencer #(
      .STEPS   (STEPS),
      .STEP_DIV(STEP_DIV),
      .GATE_DIV(GATE_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .rec      (rec),
      .note_req (note_req),
      .step_idx (step_idx),
      .note     (note),
      .gate     (gate),
      .step_tick(step_tick)
   );

   assign obs = {step_idx, note, gate, step_tick};

   task automatic model_reset();
      m_play = 0; m_pos = 0; m_step = 0; m_seen = 0; m_mon = 0;
      for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
      m_pipe[0] = '0; m_pipe[1] = '0;
      m_note = 0; m_gate = 0; m_tick = 0;
      m_exp = '0;
   endtask

   // One clock edge of the sequencer as described behaviourally.
   task automatic model_edge();
      logic [7:0] s;
      int e;
      bit r, rc, last;
      s  = m_pipe[1];
      r  = s[7];
      rc = s[6];
      e  = 0;
      for (int b = 0; b < 6; b++) if (s[b] && e == 0) e = b + 1;
      m_mon = 0;
      if (!m_play) begin
         if (r) begin
            m_play = 1; m_pos = 0; m_step = 0; m_seen = 0;
         end
      end else begin
         last = (m_pos == STEP_DIV - 1);
         if (rc && e != 0) begin
            m_pat[m_step] = e; m_seen = 1;
         end else if (rc && last && !m_seen) begin
            m_pat[m_step] = 0;
         end
         if (!r) begin
            m_play = 0; m_pos = 0;
         end else begin
            m_mon = rc && (e != 0);
            if (last) begin
               m_pos = 0; m_step = (m_step + 1) % STEPS; m_seen = 0;
            end else begin
               m_pos++;
            end
         end
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {run, rec, note_req};
      m_note = m_mon ? e : m_pat[m_step];
      m_gate = m_mon || (m_play && m_note != 0 && m_pos < GATE_DIV);
      m_tick = m_play && (m_pos == 0);
      m_exp  = {m_step[1:0], m_note[2:0], m_gate, m_tick};
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL reset_async got=%b want=%b", obs, 7'd0);
      end
      repeat (3) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp) begin
            errors++;
            $display("FAIL reset_hold t=%0t got=%b want=%b", $time, obs, m_exp);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_play_empty();
      int ticks;
      ticks = 0;
      run = 1'b1;
      for (int c = 1; c <= 3 + 4 * STEP_DIV; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp || gate !== 1'b0) begin
            errors++;
            $display("FAIL play_empty t=%0t got=%b want=%b", $time, obs, m_exp);
         end
         if (step_tick === 1'b1) begin
            checks++;
            if (c != 3 + ticks * STEP_DIV || int'(step_idx) != ticks % STEPS) begin
               errors++;
               $display("FAIL tick_sched cycle=%0d step=%0d want cycle=%0d step=%0d",
                        c, step_idx, 3 + ticks * STEP_DIV, ticks % STEPS);
            end
            ticks++;
         end
      end
      checks++;
      if (ticks != 5) begin
         errors++;
         $display("FAIL tick_count got=%0d want=5", ticks);
      end
   endtask

   // Record req during step s only, then check the next loop plays it back.
   task automatic test_record(input string name, input int s, input logic [5:0] req,
                              input int want);
      int phase, seen_cnt, gate_hi;
      bit done;
      phase = 0; seen_cnt = 0; gate_hi = 0; done = 0;
      for (int c = 0; c < 4 * STEPS * STEP_DIV && !done; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, obs, m_exp);
         end
         if (m_mon) begin
            checks++;
            if (gate !== 1'b1 || int'(note) != want) begin
               errors++;
               $display("FAIL %s_monitor gate=%b note=%0d want gate=1 note=%0d",
                        name, gate, note, want);
            end
         end
         if (phase == 0 && m_play && m_step == (s + STEPS - 1) % STEPS &&
             m_pos == STEP_DIV - 2) begin
            rec = 1'b1; note_req = req; phase = 1;
         end else if (phase == 1 && m_step == s && m_pos == STEP_DIV - 2) begin
            rec = 1'b0; note_req = 6'd0; phase = 2;
         end else if (phase == 2 && m_step == (s + 1) % STEPS) begin
            phase = 3;
         end else if (phase == 3 && m_step == s) begin
            seen_cnt++;
            if (gate === 1'b1) gate_hi++;
            checks++;
            if (int'(note) != want) begin
               errors++;
               $display("FAIL %s_playback note=%0d want=%0d", name, note, want);
            end
         end else if (phase == 3 && seen_cnt > 0) begin
            checks++;
            if (gate_hi != (want != 0 ? GATE_DIV : 0)) begin
               errors++;
               $display("FAIL %s_gate_len got=%0d want=%0d", name, gate_hi,
                        want != 0 ? GATE_DIV : 0);
            end
            done = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout phase=%0d", name, phase);
      end
   endtask

   task automatic test_stop_restart();
      int stop_c;
      bit done;
      stop_c = -1; done = 0;
      for (int c = 0; c < 4 * STEPS * STEP_DIV && !done; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp) begin
            errors++;
            $display("FAIL stop_restart t=%0t got=%b want=%b", $time, obs, m_exp);
         end
         if (stop_c >= 0) stop_c++;
         if (stop_c < 0 && m_play && m_step == 2 && m_pos == 3) begin
            run = 1'b0; stop_c = 0;
         end
         if (stop_c == 3 || stop_c == 6) begin
            checks++;
            if (step_idx !== 2'd2 || gate !== 1'b0 || step_tick !== 1'b0) begin
               errors++;
               $display("FAIL stop_state step=%0d gate=%b tick=%b want step=2 gate=0 tick=0",
                        step_idx, gate, step_tick);
            end
         end
         if (stop_c == 6) run = 1'b1;
         if (stop_c == 9) begin
            checks++;
            if (step_tick !== 1'b1 || step_idx !== 2'd0) begin
               errors++;
               $display("FAIL restart tick=%b step=%0d want tick=1 step=0", step_tick, step_idx);
            end
            done = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL stop_timeout stop_c=%0d", stop_c);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp) begin
            errors++;
            $display("FAIL random t=%0t got=%b want=%b", $time, obs, m_exp);
         end
         if ($urandom_range(0, 15) == 0) run = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) rec = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) note_req = 6'($urandom) & 6'($urandom) & 6'($urandom);
      end
   endtask

   task automatic test_reset_mid();
      bit saw;
      saw = 0;
      run = 1'b1; rec = 1'b1; note_req = 6'b000001;
      for (int c = 0; c < 64; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp) begin
            errors++;
            $display("FAIL preload t=%0t got=%b want=%b", $time, obs, m_exp);
         end
         if (gate === 1'b1) saw = 1;
         if (c == 24) begin
            rec = 1'b0; note_req = 6'd0;
         end
      end
      checks++;
      if (!saw) begin
         errors++;
         $display("FAIL preload_gate got=0 want=1");
      end
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL reset_mid got=%b want=%b", obs, 7'd0);
      end
      repeat (2) tick_cycle();
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick_cycle();
         checks++;
         if (obs !== m_exp || gate !== 1'b0) begin
            errors++;
            $display("FAIL after_reset t=%0t got=%b want=%b", $time, obs, m_exp);
         end
      end
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_play_empty();
      test_record("record", 1, 6'b000100, 3);
      test_record("lowest_bit", 2, 6'b101000, 4);
      test_record("erase", 1, 6'b000000, 0);
      test_stop_restart();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
